// File: rtl/rvjtag_pkg.sv
// rvjtag_pkg: TAP state encoding, IR codes and DMI op/status types
package rvjtag_pkg;
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;
    localparam int IR_IDCODE   = 'h01;
    localparam int IR_DTMCS    = 'h10;
    localparam int IR_DMI_BASE = 'h11;
    typedef enum logic [1:0] {DMI_NOP, DMI_READ, DMI_WRITE} dmi_op_e;
    typedef enum logic [1:0] {DMI_OK, DMI_RSV, DMI_ERR, DMI_BUSY} dmi_status_e;
endpackage

// File: rtl/rvjtag_tap_fsm.sv
// rvjtag_tap_fsm: IEEE 1149.1 16-state TAP controller with state decodes
module rvjtag_tap_fsm
    import rvjtag_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic tlr,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir
);
    tap_state_e state, nxt;
    always_comb begin
        nxt = state;
        case (state)
            TLR:    nxt = tms ? TLR    : RTI;
            RTI:    nxt = tms ? SEL_DR : RTI;
            SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: nxt = tms ? SEL_DR : RTI;
            SEL_IR: nxt = tms ? TLR    : CAP_IR;
            CAP_IR: nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: nxt = tms ? SEL_DR : RTI;
        endcase
    end
    always_ff @(posedge tck or negedge trst)
        if (!trst) state <= TLR;
        else       state <= nxt;
    assign tlr        = state == TLR;
    assign capture_dr = state == CAP_DR;
    assign shift_dr   = state == SH_DR;
    assign update_dr  = state == UPD_DR;
    assign capture_ir = state == CAP_IR;
    assign shift_ir   = state == SH_IR;
    assign update_ir  = state == UPD_IR;
endmodule

// File: rtl/rvjtag_tap_mc.sv
// rvjtag_tap_mc: multi-channel JTAG TAP / RISC-V DTM with per-channel busy/sticky tracking.
// Optional RVJTAG_DMI_TIMEOUT_EN abandons requests left outstanding for TIMEOUT tck cycles.
module rvjtag_tap_mc
    import rvjtag_pkg::*;
#(
    parameter int AWIDTH   = 7,
    parameter int NCH      = 1,
    parameter int IR_WIDTH = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_enable,
    input  logic [30:0]         jtag_id,
    input  logic [3:0]          version,
    input  logic [2:0]          idle,
    output logic [NCH-1:0]      dmi_req_valid,
    output logic [AWIDTH-1:0]   dmi_req_addr,
    output logic [31:0]         dmi_req_data,
    output logic [1:0]          dmi_req_op,
    input  logic [NCH-1:0]      dmi_resp_valid,
    input  logic [32*NCH-1:0]   dmi_resp_data,
    input  logic [2*NCH-1:0]    dmi_resp_status,
    output logic                dmi_reset,
    output logic                dmi_hard_reset
);
    localparam int SRW = AWIDTH + 34;
    logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic [SRW-1:0] sr, sr_nxt, cap;
    logic [NCH-1:0] busy, sticky, dmi_sel, resp_take, tmo, busy_eff;
    logic [AWIDTH-1:0] last_addr [NCH];
    logic [31:0] last_data [NCH];
    logic [1:0] last_st [NCH];
    logic sel_idcode, sel_dtmcs, dr_acc;
    int len;

    rvjtag_tap_fsm u_fsm (
        .tck(tck), .trst(trst), .tms(tms), .tlr(tlr),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir)
    );

    assign sel_idcode = ir == IR_WIDTH'(IR_IDCODE);
    assign sel_dtmcs  = ir == IR_WIDTH'(IR_DTMCS);
    assign dr_acc     = sr[1:0] == DMI_READ || sr[1:0] == DMI_WRITE;
    assign resp_take  = dmi_resp_valid & busy;
    assign busy_eff   = busy & ~resp_take & ~tmo;
    assign len        = (sel_idcode || sel_dtmcs) ? 32 : (|dmi_sel ? SRW : 1);

    always_comb begin
        dmi_sel = '0;
        cap     = '0;
        for (int k = 0; k < NCH; k++) dmi_sel[k] = ir == IR_WIDTH'(IR_DMI_BASE + k);
        if (sel_idcode) cap = SRW'({jtag_id, 1'b1});
        if (sel_dtmcs)  cap = SRW'({17'b0, idle, |sticky ? 2'd3 : 2'd0, 6'(AWIDTH), version});
        for (int k = 0; k < NCH; k++)
            if (dmi_sel[k]) cap = {last_addr[k], last_data[k], (busy[k] | sticky[k]) ? 2'(DMI_BUSY) : last_st[k]};
        // Shift toward bit 0, inserting tdi at the selected register's MSB
        sr_nxt = {1'b0, sr[SRW-1:1]};
        for (int i = 0; i < SRW; i++) if (i == len - 1) sr_nxt[i] = tdi;
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr             <= '0;
            ir_sr          <= '0;
            busy           <= '0;
            sticky         <= '0;
            dmi_req_valid  <= '0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= '0;
            dmi_reset      <= 1'b0;
            dmi_hard_reset <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                last_addr[k] <= '0;
                last_data[k] <= '0;
                last_st[k]   <= '0;
            end
        end else begin
            dmi_req_valid  <= '0;
            dmi_reset      <= 1'b0;
            dmi_hard_reset <= 1'b0;
            if (capture_dr)    sr <= cap;
            else if (shift_dr) sr <= sr_nxt;
            if (capture_ir)    ir_sr <= IR_WIDTH'(1);
            else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            // Responses retire before a same-edge Update-DR is judged
            for (int k = 0; k < NCH; k++) begin
                if (resp_take[k]) begin
                    busy[k]      <= 1'b0;
                    last_data[k] <= dmi_resp_data[32*k +: 32];
                    last_st[k]   <= dmi_resp_status[2*k +: 2];
                end else if (tmo[k]) begin
                    busy[k]    <= 1'b0;
                    last_st[k] <= DMI_ERR;
                end
                if (update_dr && dmi_sel[k] && dr_acc) begin
                    if (!busy_eff[k] && !sticky[k]) begin
                        busy[k]          <= 1'b1;
                        dmi_req_valid[k] <= 1'b1;
                        last_addr[k]     <= sr[SRW-1:34];
                        dmi_req_addr     <= sr[SRW-1:34];
                        dmi_req_data     <= sr[33:2];
                        dmi_req_op       <= sr[1:0];
                    end else if (busy_eff[k]) begin
                        sticky[k] <= 1'b1;
                    end
                end
            end
            if (update_dr && sel_dtmcs) begin
                if (sr[16]) begin
                    sticky    <= '0;
                    dmi_reset <= 1'b1;
                end
                if (sr[17]) begin
                    busy           <= '0;
                    sticky         <= '0;
                    dmi_req_valid  <= '0;
                    dmi_hard_reset <= 1'b1;
                end
            end
        end
    end

`ifdef RVJTAG_DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt [NCH];
    always_comb begin
        tmo = '0;
        for (int k = 0; k < NCH; k++) tmo[k] = busy[k] && cnt[k] == CW'(TIMEOUT - 1);
    end
    always_ff @(posedge tck or negedge trst)
        if (!trst) for (int k = 0; k < NCH; k++) cnt[k] <= '0;
        else       for (int k = 0; k < NCH; k++) cnt[k] <= busy_eff[k] ? cnt[k] + CW'(1) : '0;
`else
    logic unused_timeout;
    assign tmo = '0;
    assign unused_timeout = TIMEOUT != 0;
`endif

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            ir         <= IR_WIDTH'(IR_IDCODE);
            tdo        <= 1'b0;
            tdo_enable <= 1'b0;
        end else begin
            tdo        <= shift_ir ? ir_sr[0] : sr[0];
            tdo_enable <= shift_dr | shift_ir;
            if (tlr)            ir <= IR_WIDTH'(IR_IDCODE);
            else if (update_ir) ir <= (ir_sr == '0) ? '1 : ir_sr;
        end
    end
endmodule

// File: tb/tb_rvjtag_tap_mc.sv
// tb_rvjtag_tap_mc: scoreboard bench; scans push expected captures/requests, monitor pops and compares.
module tb_rvjtag_tap_mc;
`ifdef RVJTAG_DMI_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 255;
`endif
    typedef struct packed {
        logic [1:0]  v;
        logic [6:0]  a;
        logic [31:0] d;
        logic [1:0]  op;
    } req_t;

    logic tck = 1'b0, trst = 1'b0, tms = 1'b1, tdi = 1'b0;
    logic tdo, tdo_enable, dmi_reset, dmi_hard_reset;
    logic [30:0] jtag_id = 31'h0800_0045;
    logic [3:0]  version = 4'd1;
    logic [2:0]  idle = 3'd1;
    logic [1:0]  dmi_req_valid, dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_resp_valid = '0;
    logic [63:0] dmi_resp_data = '0;
    logic [3:0]  dmi_resp_status = '0;

    int tests = 0, fails = 0;
    int exp_rst = 0, exp_hrst = 0, got_rst = 0, got_hrst = 0;
    logic [127:0] exp_v[$];
    int exp_n[$];
    string exp_nm[$];
    req_t exp_req[$];

    rvjtag_tap_mc #(.AWIDTH(7), .NCH(2), .IR_WIDTH(5), .TIMEOUT(TMO)) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_enable(tdo_enable),
        .jtag_id(jtag_id), .version(version), .idle(idle),
        .dmi_req_valid(dmi_req_valid), .dmi_req_addr(dmi_req_addr),
        .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data),
        .dmi_resp_status(dmi_resp_status),
        .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 tck = ~tck;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic m, input logic d);
        @(negedge tck);
        #2;
        tms = m;
        tdi = d;
    endtask

    task automatic ir_scan(input logic [4:0] code);
        exp_v.push_back(128'h1); exp_n.push_back(5); exp_nm.push_back("ir capture");
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(i == 4, code[i]);
        tick(1, 0); tick(0, 0);
    endtask

    task automatic dr_scan(input logic [127:0] din, input int n, input logic [127:0] exp, input string nm);
        exp_v.push_back(exp); exp_n.push_back(n); exp_nm.push_back(nm);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) tick(i == n - 1, din[i]);
        tick(1, 0); tick(0, 0);
    endtask

    task automatic expect_req(input logic [1:0] v, input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        exp_req.push_back('{v: v, a: a, d: d, op: op});
    endtask

    task automatic respond(input int ch, input logic [31:0] data, input logic [1:0] st);
        @(negedge tck);
        #2;
        dmi_resp_valid[ch] = 1'b1;
        dmi_resp_data[32*ch +: 32] = data;
        dmi_resp_status[2*ch +: 2] = st;
        @(negedge tck);
        #2;
        dmi_resp_valid = '0;
    endtask

    initial begin : monitor
        logic [127:0] acc, v;
        int nb, n;
        logic prev;
        string nm;
        req_t r;
        acc = '0; nb = 0; prev = 1'b0;
        forever begin
            @(negedge tck);
            #1;
            if (tdo_enable) begin
                acc[nb] = tdo;
                nb++;
            end else if (prev) begin
                if (exp_v.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected scan: got %h (%0d bits), expected none", acc, nb);
                end else begin
                    v = exp_v.pop_front(); n = exp_n.pop_front(); nm = exp_nm.pop_front();
                    check(nm, acc & ((128'd1 << n) - 128'd1), v);
                    check({nm, " length"}, 128'(nb), 128'(n));
                end
                acc = '0;
                nb = 0;
            end
            prev = tdo_enable;
            if (|dmi_req_valid) begin
                if (exp_req.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected request: got valid=%b addr=%h data=%h op=%0d, expected none",
                             dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
                end else begin
                    r = exp_req.pop_front();
                    check("dmi request", 128'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}), 128'(r));
                end
            end
            got_rst  += int'(dmi_reset);
            got_hrst += int'(dmi_hard_reset);
        end
    end

    initial begin
        repeat (3) @(negedge tck);
        #1;
        check("reset outputs", 128'({tdo, tdo_enable, dmi_req_valid, dmi_req_addr, dmi_req_data,
                                     dmi_req_op, dmi_reset, dmi_hard_reset}), 128'h0);
        @(negedge tck);
        #2;
        trst = 1'b1;
        repeat (5) tick(1, 0);
        tick(0, 0);
        dr_scan(128'h0, 32, 128'h1000_008B, "idcode");
        ir_scan(5'h10);
        dr_scan(128'h0, 32, 128'h1071, "dtmcs");
        ir_scan(5'h00);
        dr_scan(128'hD, 4, 128'hA, "bypass");
        // channel 1 write, then response
        ir_scan(5'h12);
        expect_req(2'b10, 7'h10, 32'hDEAD_BEEF, 2'd2);
        dr_scan({7'h10, 32'hDEAD_BEEF, 2'd2}, 41, 128'h0, "ch1 write");
        respond(1, 32'h1234_5678, 2'd0);
        dr_scan(128'h0, 41, {7'h10, 32'h1234_5678, 2'd0}, "ch1 response");
        // channel 0 overlap -> sticky
        ir_scan(5'h11);
        expect_req(2'b01, 7'h05, 32'h1, 2'd2);
        dr_scan({7'h05, 32'h1, 2'd2}, 41, 128'h0, "ch0 write");
        dr_scan({7'h06, 32'h2, 2'd2}, 41, {7'h05, 32'h0, 2'd3}, "ch0 busy");
        respond(0, 32'hAAAA_5555, 2'd0);
        dr_scan({7'h07, 32'h3, 2'd1}, 41, {7'h05, 32'hAAAA_5555, 2'd3}, "ch0 sticky");
        dr_scan(128'h0, 41, {7'h05, 32'hAAAA_5555, 2'd3}, "ch0 dropped");
        ir_scan(5'h10);
        exp_rst++;
        dr_scan(128'h0001_0000, 32, 128'h1C71, "dtmcs dmistat");
        dr_scan(128'h0, 32, 128'h1071, "dtmcs sticky cleared");
        ir_scan(5'h11);
        expect_req(2'b01, 7'h07, 32'hCAFE_F00D, 2'd1);
        dr_scan({7'h07, 32'hCAFE_F00D, 2'd1}, 41, {7'h05, 32'hAAAA_5555, 2'd0}, "ch0 retry");
        // hard reset clears busy of the outstanding read
        ir_scan(5'h10);
        exp_hrst++;
        dr_scan(128'h0002_0000, 32, 128'h1071, "dtmcs hard");
        ir_scan(5'h11);
        expect_req(2'b01, 7'h09, 32'h11, 2'd2);
        dr_scan({7'h09, 32'h11, 2'd2}, 41, {7'h07, 32'hAAAA_5555, 2'd0}, "ch0 after hard reset");
        // trst while busy
        @(negedge tck);
        #2;
        trst = 1'b0;
        @(negedge tck);
        #1;
        check("trst outputs", 128'({tdo, tdo_enable, dmi_req_valid, dmi_req_addr, dmi_req_data,
                                    dmi_req_op, dmi_reset, dmi_hard_reset}), 128'h0);
        #1;
        trst = 1'b1;
        respond(0, 32'h55, 2'd2);
        tick(0, 0);
        dr_scan(128'h0, 32, 128'h1000_008B, "idcode after trst");
        ir_scan(5'h11);
        expect_req(2'b01, 7'h01, 32'h1, 2'd2);
        dr_scan({7'h01, 32'h1, 2'd2}, 41, 128'h0, "ch0 after trst");
`ifdef RVJTAG_DMI_TIMEOUT_EN
        repeat (TMO + 5) tick(0, 0);
        dr_scan(128'h0, 41, {7'h01, 32'h0, 2'd2}, "ch0 timeout");
        respond(0, 32'h77, 2'd0);
        dr_scan(128'h0, 41, {7'h01, 32'h0, 2'd2}, "ch0 late response");
`else
        respond(0, 32'h77, 2'd0);
        dr_scan(128'h0, 41, {7'h01, 32'h77, 2'd0}, "ch0 response");
`endif
        repeat (4) tick(0, 0);
        check("pending scans", 128'(exp_v.size()), 128'h0);
        check("pending requests", 128'(exp_req.size()), 128'h0);
        check("dmi_reset pulses", 128'(got_rst), 128'(exp_rst));
        check("dmi_hard_reset pulses", 128'(got_hrst), 128'(exp_hrst));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rvjtag_tap_mc.md
Name: rvjtag_tap_mc

Overview:
Parametrised multi-channel JTAG TAP / RISC-V DTM front end. It provides the IEEE 1149.1 TAP controller, IDCODE, BYPASS and DTMCS, plus NCH independent DMI access registers, each selected by its own IR code. Unlike the single-channel TAP, each channel tracks its outstanding request and reports sticky busy errors; it also drops accesses that overlap an unfinished request. It sits between the external JTAG pins and one or more debug modules.

Parameters:
AWIDTH, 7, DMI address width; 1..63.
NCH, 1, number of DMI channels; 1..8.
IR_WIDTH, 5, instruction register width; minimum 5.
TIMEOUT, 255, tck cycles before an outstanding request is abandoned (only with the optional feature).

Ports:
tck  in  1  JTAG clock; the only clock.
trst  in  1  asynchronous active-low reset.
tms  in  1  test mode select.
tdi  in  1  test data in.
tdo  out  1  test data out, updated on negedge tck.
tdo_enable  out  1  high in Shift-DR or Shift-IR.
jtag_id  in  31  IDCODE bits [31:1].
version  in  4  DTM version.
idle  in  3  DTMCS idle hint.
dmi_req_valid  out  NCH  one-hot per-channel request pulse, one tck wide.
dmi_req_addr  out  AWIDTH  request address, shared by all channels.
dmi_req_data  out  32  request write data, shared.
dmi_req_op  out  2  1 = read, 2 = write; shared.
dmi_resp_valid  in  NCH  per-channel response strobe.
dmi_resp_data  in  32*NCH  packed response data; channel k at [32k+31:32k].
dmi_resp_status  in  2*NCH  packed response status; 0 = ok, 2 = error.
dmi_reset  out  1  one-tck pulse when DTMCS bit 16 is written as 1.
dmi_hard_reset  out  1  one-tck pulse when DTMCS bit 17 is written as 1.

Behaviour:
- Clocking and reset: tck is the only clock; trst is asynchronous and active-low.
- trst low: TAP goes to Test-Logic-Reset, IR = IDCODE, and every busy, sticky, latched and output register clears. All outputs reset to 0.
- TAP: standard 16-state 1149.1 FSM, advanced on posedge tck. Five tms=1 clocks reach Test-Logic-Reset from any state.
- Test-Logic-Reset: IR = IDCODE. DMI busy and sticky state are not changed.
- IR capture loads ...01. IR updates on negedge tck in Update-IR. A written value of all-zeros becomes all-ones.
- IR codes (zero-extended to IR_WIDTH): 0x01 IDCODE; 0x10 DTMCS; 0x11+k DMI channel k for k<NCH.
- Any other IR code, including all-ones, selects the 1-bit BYPASS register, which captures 0.
- IDCODE: 32 bits, captures {jtag_id, 1'b1}.
- DTMCS: 32 bits, captures {17'b0, idle[14:12], dmistat[11:10], abits[9:4], version[3:0]}.
  - dmistat = 3 if any channel's sticky bit is set, else 0.
- DMI DR: AWIDTH+34 bits = {addr, data[33:2], op[1:0]}.
  - Capture: {last_addr[k], last_data[k], st}.
  - st = 3 if busy[k] or sticky[k]; otherwise the last response status.
- Update-DR on DMI channel k with op in {1,2}:
  - If busy[k]=0 and sticky[k]=0: drive addr/data/op, assert dmi_req_valid[k] on the next posedge for exactly one cycle, and set busy[k].
  - If busy[k]=1: set sticky[k]; no request is issued.
  - If sticky[k]=1: the access is dropped silently.
- Update-DR on DMI channel k with op = 0 or 3: no request.
- dmi_resp_valid[k] while busy[k]: clear busy[k] and latch data and status.
- dmi_resp_valid[k] while not busy[k]: ignored.
- Response and Update-DR on the same edge: the response is processed first, so the new request is accepted.
- DTMCS Update-DR:
  - bit 16 = 1: clear all sticky bits and pulse dmi_reset.
  - bit 17 = 1: clear all busy and sticky bits, cancel pending requests, and pulse dmi_hard_reset.
- tdo is sr[0], registered on negedge tck.

Optional Feature:
RVJTAG_DMI_TIMEOUT_EN:
- Defined: a per-channel counter runs while busy[k].
  - When it reaches TIMEOUT, busy[k] clears, the latched status becomes 2, and last_data is kept.
  - A later response for that request is ignored.
- Undefined: no counters; busy[k] persists until a response arrives or a DTMCS hard reset.

Decomposition:
- rvjtag_pkg holds:
  - tap_state_e, the 16 states encoded 0..15;
  - IR code constants IR_IDCODE, IR_DTMCS, IR_DMI_BASE;
  - dmi_op_e (NOP/READ/WRITE);
  - dmi_status_e (OK/RSV/ERR/BUSY).
- Sub-module rvjtag_tap_fsm holds the state register, next-state logic and state decodes (shift/capture/update for DR and IR).

Test Plan:
- tms=1 for 5 clocks, then 0 -> Run-Test/Idle. Shift 32 bits of DR -> 0x1000_008B when jtag_id=31'h0800_0045.
- IR=0x10, capture DTMCS with idle=1, version=1, AWIDTH=7 -> sr[14:0]=0x1071.
- NCH=2, IR=0x12, write addr=0x10, data=0xDEADBEEF, op=2 -> dmi_req_valid=2'b10 for one cycle, addr/data/op match; dmi_resp_valid[1] with status 0 -> next capture gives st=0.
- Second write to channel 0 before its response -> no request; capture gives st=3; DTMCS bit 16 write -> dmi_reset pulse and sticky clear; a retry issues a request.
- trst low during busy -> all outputs 0, IR=IDCODE, busy clear; a late dmi_resp_valid is ignored.
- With RVJTAG_DMI_TIMEOUT_EN and TIMEOUT=8, no response -> after 8 tck busy clears and capture gives st=2.
